// File: rtl/intercal_byte_sequencer.sv
// Byte-serial command/operand front-end for the INTERCAL ALU.
// Assembles operands, captures the ALU result, streams it back MSB-first.
module intercal_byte_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  alu_op,
    output logic        alu_wide,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_SEND
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        wide_q, wide_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;

    logic        in_acc;
    logic        out_acc;
    logic [1:0]  op_last;
    logic [1:0]  sh;

    assign in_acc  = in_valid && in_ready;
    assign out_acc = out_valid && out_ready;
    assign op_last = wide_q ? 2'd3 : 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wide_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wide_q  <= wide_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wide_d  = wide_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_acc) begin
                    op_d   = in_data[2:0];
                    wide_d = in_data[3] && (in_data[2:0] != 3'd0);
                    a_d    = '0;
                    b_d    = '0;
                    cnt_d  = '0;
                    if (in_data[2:0] > 3'd4) begin
                        // Reserved opcodes answer with a single 0xE0 byte
                        res_d   = 32'h0000_00E0;
                        last_d  = 2'd0;
                        state_d = S_SEND;
                    end else begin
                        last_d  = (in_data[3] || in_data[2:0] == 3'd0)
                                  ? 2'd3 : 2'd1;
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                if (in_acc) begin
                    a_d = {a_q[23:0], in_data};
                    if (cnt_q == op_last) begin
                        cnt_d   = '0;
                        state_d = (op_q < 3'd2) ? S_LOAD_B : S_EXEC;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_LOAD_B: begin
                if (in_acc) begin
                    b_d = {b_q[23:0], in_data};
                    if (cnt_q == op_last) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_EXEC: begin
                res_d   = alu_result;
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_acc) begin
                    if (cnt_q == last_q) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte index counts down from the top of the result window
    assign sh = last_q - cnt_q;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE, S_LOAD_A, S_LOAD_B: in_ready = 1'b1;
            S_SEND: begin
                out_valid = 1'b1;
                unique case (sh)
                    2'd0: out_data = res_q[7:0];
                    2'd1: out_data = res_q[15:8];
                    2'd2: out_data = res_q[23:16];
                    2'd3: out_data = res_q[31:24];
                endcase
            end
            default: ;
        endcase
    end

    assign alu_op   = op_q;
    assign alu_wide = wide_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;

endmodule

// File: tb/tb_intercal_byte_sequencer.sv
// Scoreboard bench for intercal_byte_sequencer with a constant model ALU.
module tb_intercal_byte_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic        alu_wide;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        busy;

    typedef struct packed {
        logic [2:0]  op;
        logic        w;
        logic [31:0] a;
        logic [31:0] b;
    } alu_exp_t;

    logic [7:0] sb[$];
    alu_exp_t   aq[$];
    int checks = 0;
    int passes = 0;

    intercal_byte_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .alu_op(alu_op),
        .alu_wide(alu_wide),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_result(alu_result),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Monitor: pops expected bytes on transfers, ALU inputs on EXEC
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL out_byte: got %h expected none", out_data);
            end else begin
                chk("out_byte", {24'h0, out_data}, {24'h0, sb.pop_front()});
            end
        end
        if (rst_n && busy && !in_ready && !out_valid) begin
            if (aq.size() == 0) begin
                checks++;
                $display("FAIL exec: got EXEC expected none");
            end else begin
                alu_exp_t e;
                e = aq.pop_front();
                chk("alu_op", {29'h0, alu_op}, {29'h0, e.op});
                chk("alu_wide", {31'h0, alu_wide}, {31'h0, e.w});
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("in_ready");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bs[$], input bit gap);
        foreach (bs[i]) send_byte(bs[i], gap);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("idle");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("out_valid");
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b1;
        alu_result = 32'h0;
        #12;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", {24'h0, out_data}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_alu_op", {29'h0, alu_op}, 32'h0);
        chk("rst_alu_wide", {31'h0, alu_wide}, 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mingle
        alu_result = 32'hAAAA_AAAA;
        aq.push_back('{3'd0, 1'b0, 32'h0000_FFFF, 32'h0});
        sb.push_back(8'hAA); sb.push_back(8'hAA);
        sb.push_back(8'hAA); sb.push_back(8'hAA);
        send_seq('{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00}, 1'b0);
        wait_idle();
        chk("mingle_busy_end", {31'h0, busy}, 32'h0);

        // 32-bit select
        alu_result = 32'h0000_0056;
        aq.push_back('{3'd1, 1'b1, 32'h1234_5678, 32'h0000_FF00});
        sb.push_back(8'h00); sb.push_back(8'h00);
        sb.push_back(8'h00); sb.push_back(8'h56);
        send_seq('{8'h09, 8'h12, 8'h34, 8'h56, 8'h78,
                   8'h00, 8'h00, 8'hFF, 8'h00}, 1'b0);
        wait_idle();

        // Unary AND 16-bit with latency checks
        alu_result = 32'hDEAD_0001;
        aq.push_back('{3'd2, 1'b0, 32'h0000_8001, 32'h0});
        sb.push_back(8'h00); sb.push_back(8'h01);
        send_seq('{8'h02, 8'h80}, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("and_exec_in_ready", {31'h0, in_ready}, 32'h0);
        chk("and_exec_out_valid", {31'h0, out_valid}, 32'h0);
        chk("and_exec_busy", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("and_send_valid", {31'h0, out_valid}, 32'h1);
        wait_idle();

        // Reserved opcode
        sb.push_back(8'hE0);
        send_byte(8'h07, 1'b0);
        chk("rsv_out_valid", {31'h0, out_valid}, 32'h1);
        chk("rsv_out_data", {24'h0, out_data}, 32'hE0);
        chk("rsv_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("rsv_idle", {31'h0, busy}, 32'h0);
        chk("rsv_idle_ready", {31'h0, in_ready}, 32'h1);

        // 16-bit select with random input gaps
        alu_result = 32'h0000_5A5A;
        aq.push_back('{3'd1, 1'b0, 32'h0000_BEEF, 32'h0000_1234});
        sb.push_back(8'h5A); sb.push_back(8'h5A);
        send_seq('{8'h01, 8'hBE, 8'hEF, 8'h12, 8'h34}, 1'b1);
        wait_idle();

        // 32-bit XOR, upper command nibble ignored, output back-pressure
        alu_result = 32'hCAFE_F00D;
        aq.push_back('{3'd4, 1'b1, 32'h1122_3344, 32'h0});
        sb.push_back(8'hCA); sb.push_back(8'hFE);
        sb.push_back(8'hF0); sb.push_back(8'h0D);
        send_seq('{8'hFC, 8'h11, 8'h22, 8'h33, 8'h44}, 1'b0);
        wait_out_valid();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", {24'h0, out_data}, 32'hFE);
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();

        // Reset after third operand byte of a binary command
        alu_result = 32'h0;
        send_seq('{8'h01, 8'h11, 8'h22, 8'h33}, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_alu_a", alu_a, 32'h0);
        chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mingle with wide bit set: still 16-bit operands
        alu_result = 32'h0102_0304;
        aq.push_back('{3'd0, 1'b0, 32'h0000_1234, 32'h0000_5678});
        sb.push_back(8'h01); sb.push_back(8'h02);
        sb.push_back(8'h03); sb.push_back(8'h04);
        send_seq('{8'h08, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b0);
        wait_idle();

        chk("sb_drained", sb.size(), 32'h0);
        chk("aq_drained", aq.size(), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/intercal_byte_sequencer.md
# intercal_byte_sequencer

Byte-serial front-end for the INTERCAL ALU core. Accepts a command byte followed by operand bytes on an 8-bit valid/ready input stream, holds the assembled opcode and operands steady on the ALU inputs, and captures the ALU result one cycle after the last operand byte. It then returns the result MSB-first on an 8-bit valid/ready output stream. It sits directly upstream of the ALU and owns all sequencing between the pin-level byte interface and the combinational ALU datapath.

## Interface
- No parameters.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input 8: command or operand byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the sequencer accepts a byte this cycle.
- `out_data` output 8: result byte.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: the consumer accepts `out_data` this cycle.
- `alu_op` output 3: latched opcode (0 mingle, 1 select, 2 unary AND, 3 unary OR, 4 unary XOR).
- `alu_wide` output 1: latched 32-bit width flag to the ALU.
- `alu_a` output 32: operand A, zero-extended.
- `alu_b` output 32: operand B, zero-extended; 0 for unary ops.
- `alu_result` input 32: combinational result from the ALU.
- `busy` output 1: high in every state except IDLE.

## Operation
- Byte transfer occurs when `in_valid && in_ready` (input side) or `out_valid && out_ready` (output side).
- Command byte fields:
  - bits 2:0 are the opcode.
  - bit 3 is `wide`.
  - bits 7:4 are ignored.
  - Mingle forces `wide`=0 because its operands are always 16-bit.
- Operand length: 4 bytes if `wide`, otherwise 2. Bytes arrive MSB-first and shift in as `reg <= {reg[23:0], byte}`.
- Result length: 4 bytes if `wide` or op=mingle, otherwise 2. Bytes are sent MSB-first from the captured 32-bit result (for a 2-byte result, bits 15:0).
- State machine:
  - IDLE: `in_ready`=1. On a command byte, latch `alu_op`/`alu_wide`, clear `alu_a`, `alu_b` and the byte counter, then go to LOAD_A. Opcodes 5–7 instead load the result register with 0x000000E0, set result length to 1 byte, and go to SEND.
  - LOAD_A: `in_ready`=1. Counts operand bytes. After the final byte, go to LOAD_B (ops 0, 1) or EXEC (ops 2–4).
  - LOAD_B: `in_ready`=1. Counts operand bytes. After the final byte, go to EXEC.
  - EXEC: `in_ready`=0. Capture `alu_result` into the result register, clear the counter, go to SEND.
  - SEND: `in_ready`=0, `out_valid`=1, `out_data` = current result byte. On each transfer, advance the counter. After the final byte, go to IDLE.
- `alu_op`, `alu_wide`, `alu_a` and `alu_b` change only:
  - in IDLE on command accept;
  - on operand byte accepts.
  They are stable through EXEC and SEND.
- `in_ready`, `out_valid`, `out_data` and `busy` are decoded from registered state only, with no combinational path from inputs.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0x00, `busy`=0, `alu_op`=0, `alu_wide`=0, `alu_a`=0, `alu_b`=0, result register 0.
- Asserting `rst_n` in any state aborts the transaction immediately, with no partial output.
- Latency: last operand byte accepted in cycle N → EXEC in cycle N+1 (ALU inputs final since the N/N+1 edge) → `out_valid`=1 in cycle N+2.
- Reserved opcode: command accepted in cycle N → `out_valid`=1 with 0xE0 in cycle N+1.
- Throughput: one byte per cycle on each stream while valid/ready are held high.
- Back-pressure: with `out_ready`=0, `out_data` and `out_valid` hold unchanged indefinitely.
- Bytes presented while `in_ready`=0 are not consumed, and the producer must hold them.
- After the last result byte transfers in cycle M, IDLE begins in cycle M+1 with `in_ready`=1, so a new command is accepted in M+1 at the earliest.
- Minimum round-trip cycles, counting the command byte, operand bytes, EXEC and result bytes with no stalls:
  - 16-bit binary: 1+2+2+1+2 = 8.
  - Mingle: 1+2+2+1+4 = 10.
  - 32-bit binary: 1+4+4+1+4 = 14.

## Test plan
- Mingle: send 0x00, FF, FF, 00, 00 → `alu_op`=0, `alu_a`=0x0000FFFF, `alu_b`=0 during EXEC. With a model ALU returning 0xAAAAAAAA, the output is AA, AA, AA, AA; `busy` falls after the fourth byte.
- 32-bit select: send 0x09, 12, 34, 56, 78, 00, 00, FF, 00 → `alu_a`=0x12345678, `alu_b`=0x0000FF00, `alu_wide`=1. With a model result of 0x00000056, the output is 00, 00, 00, 56.
- Unary AND 16-bit: send 0x02, 80, 01 → no LOAD_B, `alu_b`=0, EXEC on the cycle after byte 3, and exactly 2 output bytes (bits 15:0 of the model result).
- Reserved opcode: send 0x07 → next cycle `out_valid`=1, `out_data`=0xE0, one byte only, then IDLE. No further input bytes are consumed before IDLE.
- Back-pressure and gaps:
  - Toggle `in_valid` randomly while loading: the assembled operands are unchanged.
  - Hold `out_ready`=0 for 5 cycles mid-result: `out_data` is stable and no byte is skipped or duplicated.
- Reset mid-transaction: drop `rst_n` after the 3rd operand byte of a binary command → the same cycle shows `in_ready`=1, `busy`=0, `alu_a`=0. A following complete mingle transaction then returns correct results.
